// File: rtl/fsm_rolhamento.sv
// Corking station FSM: moves a full bottle under the press, corks it, verifies the cork and releases it.
// Optional macro CONTAGEM_REJEITOS_EN adds the CONTADOR_REJEITOS fault-entry counter port.
module fsm_rolhamento #(
   parameter int PRESS_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int CAIXA_SIZE     = 6,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 CLOCK,
   input  logic                 RESET_N,
   input  logic                 GARRAFA_CHEIA,
   input  logic                 GARRAFA_POSICAO,
   input  logic                 SENSOR_ROLHA,
   input  logic                 RECONHECE_FALHA,
   output logic                 LIBERA_ESTEIRA,
   output logic                 ATUADOR_ROLHA,
   output logic                 GARRAFA_PRONTA,
   output logic                 CAIXA_COMPLETA,
   output logic                 FALHA,
`ifdef CONTAGEM_REJEITOS_EN
   output logic [CNT_WIDTH-1:0] CONTADOR_REJEITOS,
`endif
   output logic [CNT_WIDTH-1:0] CONTADOR_TOTAL
);

   localparam int TMAX    = (PRESS_CYCLES > TIMEOUT_CYCLES) ? PRESS_CYCLES : TIMEOUT_CYCLES;
   localparam int TIMER_W = $clog2(TMAX) + 1;
   localparam int CAIXA_W = $clog2(CAIXA_SIZE) + 1;

   localparam logic [TIMER_W-1:0] PRESS_LAST = TIMER_W'(PRESS_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TMO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CAIXA_W-1:0] CAIXA_LAST = CAIXA_W'(CAIXA_SIZE - 1);

   typedef enum logic [2:0] {
      ST_OCIOSO     = 3'd0,
      ST_TRANSPORTE = 3'd1,
      ST_PRENSANDO  = 3'd2,
      ST_VERIFICA   = 3'd3,
      ST_SAIDA      = 3'd4,
      ST_FALHA      = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [TIMER_W-1:0]   r_timer;
   logic [CAIXA_W-1:0]   r_caixa;
   logic [CNT_WIDTH-1:0] r_total;
   logic                 r_pronta;
   logic                 r_caixa_pulse;
   logic                 w_bottle_ok;
   logic                 w_timed_state;

   assign w_bottle_ok   = (r_state == ST_VERIFICA) && SENSOR_ROLHA;
   assign w_timed_state = (r_state == ST_TRANSPORTE) || (r_state == ST_PRENSANDO);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_OCIOSO;
      end else begin
         r_state <= w_next;
      end
   end

   // Bottle loss beats press completion; position arrival beats transport timeout.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_OCIOSO: begin
            if (GARRAFA_CHEIA) w_next = ST_TRANSPORTE;
         end
         ST_TRANSPORTE: begin
            if (GARRAFA_POSICAO)          w_next = ST_PRENSANDO;
            else if (r_timer == TMO_LAST) w_next = ST_FALHA;
         end
         ST_PRENSANDO: begin
            if (!GARRAFA_POSICAO)           w_next = ST_FALHA;
            else if (r_timer == PRESS_LAST) w_next = ST_VERIFICA;
         end
         ST_VERIFICA: begin
            w_next = SENSOR_ROLHA ? ST_SAIDA : ST_FALHA;
         end
         ST_SAIDA: begin
            if (!GARRAFA_POSICAO) w_next = ST_OCIOSO;
         end
         ST_FALHA: begin
            if (RECONHECE_FALHA && !GARRAFA_POSICAO) w_next = ST_OCIOSO;
         end
         default: w_next = ST_OCIOSO;
      endcase
   end

   always_comb begin
      LIBERA_ESTEIRA = 1'b0;
      ATUADOR_ROLHA  = 1'b0;
      FALHA          = 1'b0;
      case (r_state)
         ST_TRANSPORTE: LIBERA_ESTEIRA = 1'b1;
         ST_PRENSANDO:  ATUADOR_ROLHA  = 1'b1;
         ST_SAIDA:      LIBERA_ESTEIRA = 1'b1;
         ST_FALHA:      FALHA          = 1'b1;
         default: ;
      endcase
   end

   // Timer restarts on every state change so each timed state starts counting from zero.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_timer <= '0;
      end else if ((w_next != r_state) || !w_timed_state) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + TIMER_W'(1);
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_caixa       <= '0;
         r_total       <= '0;
         r_pronta      <= 1'b0;
         r_caixa_pulse <= 1'b0;
      end else begin
         r_pronta      <= w_bottle_ok;
         r_caixa_pulse <= w_bottle_ok && (r_caixa == CAIXA_LAST);
         if (w_bottle_ok) begin
            if (r_caixa == CAIXA_LAST) r_caixa <= '0;
            else                       r_caixa <= r_caixa + CAIXA_W'(1);
            if (r_total != '1)         r_total <= r_total + CNT_WIDTH'(1);
         end
      end
   end

   assign GARRAFA_PRONTA = r_pronta;
   assign CAIXA_COMPLETA = r_caixa_pulse;
   assign CONTADOR_TOTAL = r_total;

`ifdef CONTAGEM_REJEITOS_EN
   logic [CNT_WIDTH-1:0] r_rejeitos;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_rejeitos <= '0;
      end else if ((w_next == ST_FALHA) && (r_state != ST_FALHA) && (r_rejeitos != '1)) begin
         r_rejeitos <= r_rejeitos + CNT_WIDTH'(1);
      end
   end

   assign CONTADOR_REJEITOS = r_rejeitos;
`endif

endmodule

// File: tb/tb_fsm_rolhamento.sv
// Directed self-checking bench for fsm_rolhamento (PRESS=4, TIMEOUT=10, CAIXA=3, 2-bit counters).
module tb_fsm_rolhamento;

   localparam int PRESS = 4;
   localparam int TMO   = 10;
   localparam int CX    = 3;
   localparam int CW    = 2;

   logic          CLOCK;
   logic          RESET_N;
   logic          GARRAFA_CHEIA;
   logic          GARRAFA_POSICAO;
   logic          SENSOR_ROLHA;
   logic          RECONHECE_FALHA;
   logic          LIBERA_ESTEIRA;
   logic          ATUADOR_ROLHA;
   logic          GARRAFA_PRONTA;
   logic          CAIXA_COMPLETA;
   logic          FALHA;
   logic [CW-1:0] CONTADOR_TOTAL;
`ifdef CONTAGEM_REJEITOS_EN
   logic [CW-1:0] CONTADOR_REJEITOS;
`endif

   int n_cmp = 0;
   int n_err = 0;

   fsm_rolhamento #(
      .PRESS_CYCLES  (PRESS),
      .TIMEOUT_CYCLES(TMO),
      .CAIXA_SIZE    (CX),
      .CNT_WIDTH     (CW)
   ) dut (
      .CLOCK            (CLOCK),
      .RESET_N          (RESET_N),
      .GARRAFA_CHEIA    (GARRAFA_CHEIA),
      .GARRAFA_POSICAO  (GARRAFA_POSICAO),
      .SENSOR_ROLHA     (SENSOR_ROLHA),
      .RECONHECE_FALHA  (RECONHECE_FALHA),
      .LIBERA_ESTEIRA   (LIBERA_ESTEIRA),
      .ATUADOR_ROLHA    (ATUADOR_ROLHA),
      .GARRAFA_PRONTA   (GARRAFA_PRONTA),
      .CAIXA_COMPLETA   (CAIXA_COMPLETA),
      .FALHA            (FALHA),
`ifdef CONTAGEM_REJEITOS_EN
      .CONTADOR_REJEITOS(CONTADOR_REJEITOS),
`endif
      .CONTADOR_TOTAL   (CONTADOR_TOTAL)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic apply_reset();
      RESET_N         = 1'b0;
      GARRAFA_CHEIA   = 1'b0;
      GARRAFA_POSICAO = 1'b0;
      SENSOR_ROLHA    = 1'b0;
      RECONHECE_FALHA = 1'b0;
      tick();
      RESET_N = 1'b1;
   endtask

   // One full bottle pass over 11 clocks; only gathers observations.
   task automatic drive_bottle(input logic sensor, output int lib_n, output int atu_n,
                               output int pr_n, output int cx_n, output int coinc_n);
      lib_n = 0; atu_n = 0; pr_n = 0; cx_n = 0; coinc_n = 0;
      GARRAFA_CHEIA = 1'b1;
      SENSOR_ROLHA  = sensor;
      for (int k = 1; k <= 11; k++) begin
         if (k == 2)  GARRAFA_CHEIA   = 1'b0;
         if (k == 4)  GARRAFA_POSICAO = 1'b1;
         if (k == 11) GARRAFA_POSICAO = 1'b0;
         tick();
         if (LIBERA_ESTEIRA) lib_n++;
         if (ATUADOR_ROLHA)  atu_n++;
         if (GARRAFA_PRONTA) pr_n++;
         if (CAIXA_COMPLETA) cx_n++;
         if (CAIXA_COMPLETA && GARRAFA_PRONTA) coinc_n++;
      end
   endtask

   task automatic test_reset();
      RESET_N         = 1'b0;
      GARRAFA_CHEIA   = 1'b0;
      GARRAFA_POSICAO = 1'b0;
      SENSOR_ROLHA    = 1'b0;
      RECONHECE_FALHA = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({LIBERA_ESTEIRA, ATUADOR_ROLHA, GARRAFA_PRONTA, CAIXA_COMPLETA, FALHA} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {LIBERA_ESTEIRA, ATUADOR_ROLHA, GARRAFA_PRONTA, CAIXA_COMPLETA, FALHA});
      end
      n_cmp++;
      if (CONTADOR_TOTAL !== '0) begin
         n_err++; $display("FAIL reset_total: got %0d want 0", CONTADOR_TOTAL);
      end
      RESET_N = 1'b1;
   endtask

   task automatic test_good_bottle();
      int lib_n = 0;
      int atu_n = 0;
      apply_reset();
      GARRAFA_CHEIA = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         if (k == 2) GARRAFA_CHEIA = 1'b0;
         tick();
         if (LIBERA_ESTEIRA) lib_n++;
      end
      n_cmp++;
      if (lib_n !== 3) begin n_err++; $display("FAIL t1_libera_cycles: got %0d want 3", lib_n); end
      GARRAFA_POSICAO = 1'b1;
      SENSOR_ROLHA    = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (ATUADOR_ROLHA) atu_n++;
      end
      n_cmp++;
      if (atu_n !== PRESS) begin n_err++; $display("FAIL t1_press_cycles: got %0d want %0d", atu_n, PRESS); end
      n_cmp++;
      if ({LIBERA_ESTEIRA, ATUADOR_ROLHA, GARRAFA_PRONTA} !== 3'b000) begin
         n_err++; $display("FAIL t1_verifica_outputs: got %b want 000", {LIBERA_ESTEIRA, ATUADOR_ROLHA, GARRAFA_PRONTA});
      end
      tick();
      n_cmp++;
      if ({GARRAFA_PRONTA, LIBERA_ESTEIRA, CAIXA_COMPLETA} !== 3'b110) begin
         n_err++; $display("FAIL t1_saida_pulse: got %b want 110", {GARRAFA_PRONTA, LIBERA_ESTEIRA, CAIXA_COMPLETA});
      end
      n_cmp++;
      if (CONTADOR_TOTAL !== CW'(1)) begin n_err++; $display("FAIL t1_total: got %0d want 1", CONTADOR_TOTAL); end
      tick();
      n_cmp++;
      if ({GARRAFA_PRONTA, LIBERA_ESTEIRA} !== 2'b01) begin
         n_err++; $display("FAIL t1_pulse_width: got %b want 01", {GARRAFA_PRONTA, LIBERA_ESTEIRA});
      end
      GARRAFA_POSICAO = 1'b0;
      tick();
      n_cmp++;
      if ({LIBERA_ESTEIRA, FALHA} !== 2'b00) begin
         n_err++; $display("FAIL t1_back_to_idle: got %b want 00", {LIBERA_ESTEIRA, FALHA});
      end
   endtask

   task automatic test_caixa();
      int lib_n, atu_n, pr_n, cx_n, co_n;
      int exp_cx[4]  = '{0, 0, 1, 0};
      int exp_tot[4] = '{1, 2, 3, 3};
      apply_reset();
      for (int b = 0; b < 4; b++) begin
         drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
         n_cmp++;
         if (pr_n !== 1) begin n_err++; $display("FAIL t2_pronta b%0d: got %0d want 1", b, pr_n); end
         n_cmp++;
         if (cx_n !== exp_cx[b] || co_n !== exp_cx[b]) begin
            n_err++; $display("FAIL t2_caixa b%0d: got %0d/%0d want %0d", b, cx_n, co_n, exp_cx[b]);
         end
         n_cmp++;
         if (CONTADOR_TOTAL !== CW'(exp_tot[b])) begin
            n_err++; $display("FAIL t2_total b%0d: got %0d want %0d", b, CONTADOR_TOTAL, exp_tot[b]);
         end
         n_cmp++;
         if (lib_n !== 5 || atu_n !== PRESS) begin
            n_err++; $display("FAIL t2_actuators b%0d: got lib %0d atu %0d want 5 %0d", b, lib_n, atu_n, PRESS);
         end
      end
   endtask

   task automatic test_timeout();
      int lib_n = 0;
      int f_n   = 0;
      apply_reset();
      GARRAFA_CHEIA = 1'b1;
      for (int k = 1; k <= TMO; k++) begin
         if (k == 2) GARRAFA_CHEIA = 1'b0;
         tick();
         if (LIBERA_ESTEIRA) lib_n++;
         if (FALHA) f_n++;
      end
      n_cmp++;
      if (lib_n !== TMO || f_n !== 0) begin
         n_err++; $display("FAIL t3_transport: got lib %0d falha %0d want %0d 0", lib_n, f_n, TMO);
      end
      tick();
      n_cmp++;
      if ({FALHA, LIBERA_ESTEIRA} !== 2'b10) begin
         n_err++; $display("FAIL t3_timeout_fault: got %b want 10", {FALHA, LIBERA_ESTEIRA});
      end
`ifdef CONTAGEM_REJEITOS_EN
      n_cmp++;
      if (CONTADOR_REJEITOS !== CW'(1)) begin
         n_err++; $display("FAIL t3_rejeitos: got %0d want 1", CONTADOR_REJEITOS);
      end
`endif
      GARRAFA_POSICAO = 1'b1;
      RECONHECE_FALHA = 1'b1;
      tick();
      n_cmp++;
      if (FALHA !== 1'b1) begin n_err++; $display("FAIL t3_ack_with_bottle: got %b want 1", FALHA); end
      GARRAFA_POSICAO = 1'b0;
      tick();
      n_cmp++;
      if ({FALHA, LIBERA_ESTEIRA} !== 2'b00) begin
         n_err++; $display("FAIL t3_ack_clear: got %b want 00", {FALHA, LIBERA_ESTEIRA});
      end
      RECONHECE_FALHA = 1'b0;
   endtask

   task automatic test_position_wins();
      apply_reset();
      GARRAFA_CHEIA = 1'b1;
      for (int k = 1; k <= TMO; k++) begin
         if (k == 2) GARRAFA_CHEIA = 1'b0;
         tick();
      end
      GARRAFA_POSICAO = 1'b1;
      tick();
      n_cmp++;
      if ({ATUADOR_ROLHA, FALHA} !== 2'b10) begin
         n_err++; $display("FAIL t3b_position_wins: got %b want 10", {ATUADOR_ROLHA, FALHA});
      end
   endtask

   task automatic test_missing_cork();
      int lib_n, atu_n, pr_n, cx_n, co_n;
      apply_reset();
      drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
      drive_bottle(1'b0, lib_n, atu_n, pr_n, cx_n, co_n);
      n_cmp++;
      if (pr_n !== 0 || FALHA !== 1'b1) begin
         n_err++; $display("FAIL t4_cork_fault: got pronta %0d falha %b want 0 1", pr_n, FALHA);
      end
      n_cmp++;
      if (CONTADOR_TOTAL !== CW'(1)) begin n_err++; $display("FAIL t4_total_held: got %0d want 1", CONTADOR_TOTAL); end
`ifdef CONTAGEM_REJEITOS_EN
      n_cmp++;
      if (CONTADOR_REJEITOS !== CW'(1)) begin
         n_err++; $display("FAIL t4_rejeitos: got %0d want 1", CONTADOR_REJEITOS);
      end
`endif
      RECONHECE_FALHA = 1'b1;
      tick();
      RECONHECE_FALHA = 1'b0;
      n_cmp++;
      if (FALHA !== 1'b0) begin n_err++; $display("FAIL t4_ack: got %b want 0", FALHA); end
   endtask

   task automatic test_bottle_removed();
      apply_reset();
      GARRAFA_CHEIA = 1'b1;
      tick();
      GARRAFA_CHEIA = 1'b0;
      tick();
      tick();
      GARRAFA_POSICAO = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (ATUADOR_ROLHA !== 1'b1) begin n_err++; $display("FAIL t5_pressing: got %b want 1", ATUADOR_ROLHA); end
      GARRAFA_POSICAO = 1'b0;
      tick();
      n_cmp++;
      if ({ATUADOR_ROLHA, FALHA} !== 2'b01) begin
         n_err++; $display("FAIL t5_removed: got %b want 01", {ATUADOR_ROLHA, FALHA});
      end
`ifdef CONTAGEM_REJEITOS_EN
      n_cmp++;
      if (CONTADOR_REJEITOS !== CW'(1)) begin
         n_err++; $display("FAIL t5_rejeitos: got %0d want 1", CONTADOR_REJEITOS);
      end
`endif
   endtask

   task automatic test_async_reset();
      int lib_n, atu_n, pr_n, cx_n, co_n;
      apply_reset();
      drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
      GARRAFA_CHEIA = 1'b1;
      tick();
      GARRAFA_CHEIA = 1'b0;
      tick();
      tick();
      GARRAFA_POSICAO = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (ATUADOR_ROLHA !== 1'b1) begin n_err++; $display("FAIL t6_pressing: got %b want 1", ATUADOR_ROLHA); end
      RESET_N = 1'b0;
      #1;
      n_cmp++;
      if ({ATUADOR_ROLHA, CONTADOR_TOTAL} !== {1'b0, CW'(0)}) begin
         n_err++; $display("FAIL t6_async_drop: got atu %b total %0d want 0 0", ATUADOR_ROLHA, CONTADOR_TOTAL);
      end
      GARRAFA_POSICAO = 1'b0;
      tick();
      RESET_N = 1'b1;
      tick();
      n_cmp++;
      if ({LIBERA_ESTEIRA, ATUADOR_ROLHA, FALHA} !== 3'b000) begin
         n_err++; $display("FAIL t6_idle_after: got %b want 000", {LIBERA_ESTEIRA, ATUADOR_ROLHA, FALHA});
      end
      drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
      drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
      n_cmp++;
      if (cx_n !== 0) begin n_err++; $display("FAIL t6_caixa_cleared b2: got %0d want 0", cx_n); end
      drive_bottle(1'b1, lib_n, atu_n, pr_n, cx_n, co_n);
      n_cmp++;
      if (cx_n !== 1) begin n_err++; $display("FAIL t6_caixa_cleared b3: got %0d want 1", cx_n); end
   endtask

   task automatic test_back_to_back();
      int pr_n = 0;
      apply_reset();
      GARRAFA_CHEIA = 1'b1;
      SENSOR_ROLHA  = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         if (k == 4)  GARRAFA_POSICAO = 1'b1;
         if (k == 11) GARRAFA_POSICAO = 1'b0;
         tick();
         if (GARRAFA_PRONTA) pr_n++;
      end
      n_cmp++;
      if ({LIBERA_ESTEIRA, pr_n == 1} !== 2'b01) begin
         n_err++; $display("FAIL t7_idle_then_pronta: got lib %b pronta %0d want 0 1", LIBERA_ESTEIRA, pr_n);
      end
      tick();
      n_cmp++;
      if (LIBERA_ESTEIRA !== 1'b1) begin n_err++; $display("FAIL t7_restart: got %b want 1", LIBERA_ESTEIRA); end
      GARRAFA_CHEIA = 1'b0;
   endtask

   initial begin
      test_reset();
      test_good_bottle();
      test_caixa();
      test_timeout();
      test_position_wins();
      test_missing_cork();
      test_bottle_removed();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
